// File: rtl/hdc_search_pkg.sv
// Shared constants, derived widths and the FSM state type for the
// hypervector associative search block.
package hdc_search_pkg;

  // Hypervector geometry and class count
  localparam int HV_DIM      = 4096;
  localparam int CLASS_COUNT = 26;
  localparam int CHUNK_W     = 1024;

  // Widths derived from the geometry above
  localparam int CHUNKS      = HV_DIM / CHUNK_W;
  localparam int DIST_W      = $clog2(HV_DIM + 1);
  localparam int CLS_W       = $clog2(CLASS_COUNT);
  localparam int CHUNK_CTR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int POP_W       = $clog2(CHUNK_W + 1);

  // Search sequencer states
  typedef enum logic [1:0] {
    IDLE,
    DIST,
    ARGMIN,
    DONE
  } search_state_t;

endpackage

// File: rtl/hdc_chunk_popcount.sv
// Combinational Hamming distance of one chunk: XOR the query and class
// slices, drop masked-out dimensions, and count the remaining ones.
module hdc_chunk_popcount
  import hdc_search_pkg::*;
#(
  parameter int W     = CHUNK_W,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     i_query,
  input  logic [W-1:0]     i_class,
  input  logic [W-1:0]     i_mask,
  output logic [CNT_W-1:0] o_count
);

  logic [W-1:0] w_diff;

  // Differing, unmasked bits are summed one at a time; synthesis folds this into an adder tree
  always_comb begin
    w_diff  = (i_query ^ i_class) & i_mask;
    o_count = '0;
    for (int i = 0; i < W; i++) begin
      o_count = o_count + CNT_W'(w_diff[i]);
    end
  end

endmodule

// File: rtl/hdc_assoc_search.sv
// Associative search over stored class hypervectors: accumulates Hamming
// distances chunk by chunk, then scans for the closest class.
// Optional build macro: HDC_RP_MASK_EN adds a dimension-pruning mask.
module hdc_assoc_search
  import hdc_search_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              class_wr_en,
  input  logic [CLS_W-1:0]  class_wr_addr,
  input  logic [HV_DIM-1:0] class_wr_data,
  input  logic              start_search,
  input  logic [HV_DIM-1:0] query_hv,
`ifdef HDC_RP_MASK_EN
  input  logic              mask_wr_en,
  input  logic [HV_DIM-1:0] mask_wr_data,
`endif
  output logic              busy,
  output logic              search_done,
  output logic [CLS_W-1:0]  predicted_class,
  output logic [DIST_W-1:0] min_distance
);

  search_state_t r_state;
  search_state_t w_nextState;

  logic [HV_DIM-1:0]      r_classMem [CLASS_COUNT];
  logic [HV_DIM-1:0]      r_query;
  logic [DIST_W-1:0]      r_acc [CLASS_COUNT];
  logic [CHUNK_CTR_W-1:0] r_chunkCtr;
  logic [CLS_W-1:0]       r_clsCtr;
  logic [CLS_W-1:0]       r_bestIdx;
  logic [DIST_W-1:0]      r_bestDist;
  logic                   r_searchDone;
  logic [CLS_W-1:0]       r_predClass;
  logic [DIST_W-1:0]      r_minDist;

  int                     w_chunkBase;
  logic                   w_lastChunk;
  logic                   w_lastClass;
  logic                   w_classWrOk;
  logic [CHUNK_W-1:0]     w_queryChunk;
  logic [CHUNK_W-1:0]     w_maskChunk;
  logic [CHUNK_W-1:0]     w_classChunk [CLASS_COUNT];
  logic [POP_W-1:0]       w_popCount [CLASS_COUNT];

  assign w_chunkBase  = int'(r_chunkCtr) * CHUNK_W;
  assign w_lastChunk  = (r_chunkCtr == CHUNK_CTR_W'(CHUNKS - 1));
  assign w_lastClass  = (r_clsCtr == CLS_W'(CLASS_COUNT - 1));
  assign w_queryChunk = r_query[w_chunkBase +: CHUNK_W];
  // Class memory may only change while idle so a running search sees stable contents
  assign w_classWrOk  = en && class_wr_en && (r_state == IDLE) &&
                        (int'(class_wr_addr) < CLASS_COUNT);

`ifdef HDC_RP_MASK_EN
  logic [HV_DIM-1:0] r_mask;

  // Pruning mask: all dimensions count after reset, rewritable only while idle
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_mask <= '1;
    end else if (en && mask_wr_en && (r_state == IDLE)) begin
      r_mask <= mask_wr_data;
    end
  end

  assign w_maskChunk = r_mask[w_chunkBase +: CHUNK_W];
`else
  assign w_maskChunk = '1;
`endif

  // Class register file; deliberately not reset, contents are valid only once written
  always_ff @(posedge clk) begin
    if (w_classWrOk) begin
      r_classMem[class_wr_addr] <= class_wr_data;
    end
  end

  for (genvar g = 0; g < CLASS_COUNT; g++) begin : g_pop
    assign w_classChunk[g] = r_classMem[g][w_chunkBase +: CHUNK_W];

    hdc_chunk_popcount #(
      .W     (CHUNK_W),
      .CNT_W (POP_W)
    ) u_pop (
      .i_query (w_queryChunk),
      .i_class (w_classChunk[g]),
      .i_mask  (w_maskChunk),
      .o_count (w_popCount[g])
    );
  end

  // State register; a low enable freezes the sequencer in place
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_state <= IDLE;
    end else if (en) begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode: distance pass, argmin scan, one done cycle
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start_search) w_nextState = DIST;
      DIST:    if (w_lastChunk)  w_nextState = ARGMIN;
      ARGMIN:  if (w_lastClass)  w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Busy covers every non-idle state, including the done cycle
  always_comb begin
    busy = 1'b0;
    case (r_state)
      DIST, ARGMIN, DONE: busy = 1'b1;
      default:            busy = 1'b0;
    endcase
  end

  // Datapath: query capture, distance accumulation, argmin tracking and result registers
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      r_query      <= '0;
      r_chunkCtr   <= '0;
      r_clsCtr     <= '0;
      r_bestIdx    <= '0;
      r_bestDist   <= '0;
      r_searchDone <= 1'b0;
      r_predClass  <= '0;
      r_minDist    <= '0;
      for (int c = 0; c < CLASS_COUNT; c++) begin
        r_acc[c] <= '0;
      end
    end else if (en) begin
      r_searchDone <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start_search) begin
            r_query    <= query_hv;
            r_chunkCtr <= '0;
            for (int c = 0; c < CLASS_COUNT; c++) begin
              r_acc[c] <= '0;
            end
          end
        end
        DIST: begin
          for (int c = 0; c < CLASS_COUNT; c++) begin
            r_acc[c] <= r_acc[c] + DIST_W'(w_popCount[c]);
          end
          r_chunkCtr <= r_chunkCtr + CHUNK_CTR_W'(1);
          if (w_lastChunk) begin
            r_clsCtr   <= '0;
            r_bestIdx  <= '0;
            r_bestDist <= '1;
          end
        end
        ARGMIN: begin
          if (r_acc[r_clsCtr] < r_bestDist) begin
            r_bestIdx  <= r_clsCtr;
            r_bestDist <= r_acc[r_clsCtr];
          end
          r_clsCtr <= r_clsCtr + CLS_W'(1);
        end
        DONE: begin
          r_predClass <= r_bestIdx;
          r_minDist   <= r_bestDist;
        end
        default: begin
          r_chunkCtr <= '0;
        end
      endcase
    end
  end

  assign search_done     = r_searchDone;
  assign predicted_class = r_predClass;
  assign min_distance    = r_minDist;

endmodule

// File: tb/tb_hdc_assoc_search.sv
// Directed self-checking bench for hdc_assoc_search.
// Build with HDC_RP_MASK_EN defined to also exercise the pruning mask.
module tb_hdc_assoc_search;
  import hdc_search_pkg::*;

  logic              clk;
  logic              nrst;
  logic              en;
  logic              class_wr_en;
  logic [CLS_W-1:0]  class_wr_addr;
  logic [HV_DIM-1:0] class_wr_data;
  logic              start_search;
  logic [HV_DIM-1:0] query_hv;
`ifdef HDC_RP_MASK_EN
  logic              mask_wr_en;
  logic [HV_DIM-1:0] mask_wr_data;
`endif
  logic              busy;
  logic              search_done;
  logic [CLS_W-1:0]  predicted_class;
  logic [DIST_W-1:0] min_distance;

  int assertCount = 0;
  int failCount   = 0;

  logic [HV_DIM-1:0] classVec [CLASS_COUNT];
  logic [HV_DIM-1:0] chunkQuery;

  hdc_assoc_search dut (
    .clk             (clk),
    .nrst            (nrst),
    .en              (en),
    .class_wr_en     (class_wr_en),
    .class_wr_addr   (class_wr_addr),
    .class_wr_data   (class_wr_data),
    .start_search    (start_search),
    .query_hv        (query_hv),
`ifdef HDC_RP_MASK_EN
    .mask_wr_en      (mask_wr_en),
    .mask_wr_data    (mask_wr_data),
`endif
    .busy            (busy),
    .search_done     (search_done),
    .predicted_class (predicted_class),
    .min_distance    (min_distance)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [HV_DIM-1:0] randHv();
    logic [HV_DIM-1:0] v;
    for (int i = 0; i < HV_DIM / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic applyStimulus(input int addr, input logic [HV_DIM-1:0] data);
    logic [31:0] a;
    a = addr;
    @(negedge clk);
    class_wr_en   = 1'b1;
    class_wr_addr = a[CLS_W-1:0];
    class_wr_data = data;
    @(negedge clk);
    class_wr_en   = 1'b0;
  endtask

  task automatic loadClasses();
    for (int c = 0; c < CLASS_COUNT; c++) applyStimulus(c, classVec[c]);
  endtask

  // Returns at the falling edge just after the accepting rising edge
  task automatic launch(input logic [HV_DIM-1:0] q);
    @(negedge clk);
    query_hv     = q;
    start_search = 1'b1;
    @(negedge clk);
    start_search = 1'b0;
  endtask

  task automatic waitDone(output int cycles, output int busyCycles);
    cycles     = 0;
    busyCycles = busy ? 1 : 0;
    while (!search_done && cycles < 100) begin
      @(negedge clk);
      cycles++;
      if (busy) busyCycles++;
    end
  endtask

  task automatic test_reset();
    #1;
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: actual %0b required 0", busy); end
    assertCount++; if (search_done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: actual %0b required 0", search_done); end
    assertCount++; if (predicted_class !== '0) begin failCount++; $display("[TB] FAIL reset_class: actual %0d required 0", predicted_class); end
    assertCount++; if (min_distance !== '0) begin failCount++; $display("[TB] FAIL reset_dist: actual %0d required 0", min_distance); end
    @(negedge clk);
    nrst = 1'b0;
  endtask

  task automatic test_exact_match();
    int cyc, bcyc;
    classVec[0] = '0;
    classVec[1] = '1;
    for (int c = 2; c < CLASS_COUNT; c++) classVec[c] = randHv();
    loadClasses();
    launch('0);
    waitDone(cyc, bcyc);
    assertCount++; if (cyc !== 31) begin failCount++; $display("[TB] FAIL exact_latency: actual %0d required 31", cyc); end
    assertCount++; if (bcyc !== 31) begin failCount++; $display("[TB] FAIL exact_busy_len: actual %0d required 31", bcyc); end
    assertCount++; if (predicted_class !== 5'd0) begin failCount++; $display("[TB] FAIL exact_class: actual %0d required 0", predicted_class); end
    assertCount++; if (min_distance !== 13'd0) begin failCount++; $display("[TB] FAIL exact_dist: actual %0d required 0", min_distance); end
    @(negedge clk);
    assertCount++; if (search_done !== 1'b0) begin failCount++; $display("[TB] FAIL exact_done_pulse: actual %0b required 0", search_done); end
  endtask

  task automatic test_ties();
    int cyc, bcyc;
    logic [HV_DIM-1:0] q;
    q = randHv();
    for (int c = 0; c < CLASS_COUNT; c++) begin
      classVec[c] = q;
      if (c != 3 && c != 5) begin
        for (int i = 0; i < 100 + c; i++) classVec[c][i] = ~classVec[c][i];
      end
    end
    loadClasses();
    launch(q);
    waitDone(cyc, bcyc);
    assertCount++; if (predicted_class !== 5'd3) begin failCount++; $display("[TB] FAIL ties_class: actual %0d required 3", predicted_class); end
    assertCount++; if (min_distance !== 13'd0) begin failCount++; $display("[TB] FAIL ties_dist: actual %0d required 0", min_distance); end
  endtask

  task automatic test_chunk_accounting();
    int cyc, bcyc;
    logic [HV_DIM-1:0] r;
    r = randHv();
    chunkQuery = r;
    chunkQuery[HV_DIM-1] = ~chunkQuery[HV_DIM-1];
    for (int i = 0; i < 10; i++) chunkQuery[i] = ~chunkQuery[i];
    for (int c = 0; c < CLASS_COUNT; c++) begin
      classVec[c] = chunkQuery;
      if (c == 7) classVec[c] = r;
      else for (int i = 200; i < 212 + c; i++) classVec[c][i] = ~classVec[c][i];
    end
    loadClasses();
    launch(chunkQuery);
    waitDone(cyc, bcyc);
    assertCount++; if (predicted_class !== 5'd7) begin failCount++; $display("[TB] FAIL chunk_class: actual %0d required 7", predicted_class); end
    assertCount++; if (min_distance !== 13'd11) begin failCount++; $display("[TB] FAIL chunk_dist: actual %0d required 11", min_distance); end
  endtask

  task automatic test_protocol();
    int cyc, bcyc;
    launch(chunkQuery);
    cyc  = 0;
    bcyc = busy ? 1 : 0;
    while (!search_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (busy) bcyc++;
      if (cyc == 3) begin
        class_wr_en = 1'b1; class_wr_addr = 5'd7; class_wr_data = chunkQuery;
      end
      if (cyc == 4) class_wr_en = 1'b0;
      if (cyc == 5) begin
        start_search = 1'b1; query_hv = ~chunkQuery;
      end
      if (cyc == 6) start_search = 1'b0;
    end
    assertCount++; if (cyc !== 31) begin failCount++; $display("[TB] FAIL proto_latency: actual %0d required 31", cyc); end
    assertCount++; if (bcyc !== 31) begin failCount++; $display("[TB] FAIL proto_busy_len: actual %0d required 31", bcyc); end
    assertCount++; if (predicted_class !== 5'd7) begin failCount++; $display("[TB] FAIL proto_class: actual %0d required 7", predicted_class); end
    assertCount++; if (min_distance !== 13'd11) begin failCount++; $display("[TB] FAIL proto_dist: actual %0d required 11", min_distance); end
    repeat (3) @(negedge clk);
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL proto_no_restart: actual %0b required 0", busy); end
  endtask

  task automatic test_enable_freeze();
    int cyc, bcyc;
    launch(chunkQuery);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    assertCount++; if (busy !== 1'b1) begin failCount++; $display("[TB] FAIL freeze_busy: actual %0b required 1", busy); end
    en = 1'b1;
    waitDone(cyc, bcyc);
    assertCount++; if (cyc + 8 !== 36) begin failCount++; $display("[TB] FAIL freeze_latency: actual %0d required 36", cyc + 8); end
    assertCount++; if (min_distance !== 13'd11) begin failCount++; $display("[TB] FAIL freeze_dist: actual %0d required 11", min_distance); end
    en = 1'b0;
    repeat (3) @(negedge clk);
    assertCount++; if (search_done !== 1'b1) begin failCount++; $display("[TB] FAIL freeze_done_hold: actual %0b required 1", search_done); end
    en = 1'b1;
    @(negedge clk);
    assertCount++; if (search_done !== 1'b0) begin failCount++; $display("[TB] FAIL freeze_done_clear: actual %0b required 0", search_done); end
  endtask

  task automatic test_reset_mid_search();
    int cyc, bcyc;
    launch(chunkQuery);
    repeat (10) @(negedge clk);
    nrst = 1'b1;
    #1;
    assertCount++; if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_busy: actual %0b required 0", busy); end
    assertCount++; if (search_done !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_done: actual %0b required 0", search_done); end
    assertCount++; if (predicted_class !== 5'd0) begin failCount++; $display("[TB] FAIL midrst_class: actual %0d required 0", predicted_class); end
    assertCount++; if (min_distance !== 13'd0) begin failCount++; $display("[TB] FAIL midrst_dist: actual %0d required 0", min_distance); end
    @(negedge clk);
    nrst = 1'b0;
    launch(chunkQuery);
    waitDone(cyc, bcyc);
    assertCount++; if (cyc !== 31) begin failCount++; $display("[TB] FAIL midrst_latency: actual %0d required 31", cyc); end
    assertCount++; if (predicted_class !== 5'd7) begin failCount++; $display("[TB] FAIL midrst_class_after: actual %0d required 7", predicted_class); end
    assertCount++; if (min_distance !== 13'd11) begin failCount++; $display("[TB] FAIL midrst_dist_after: actual %0d required 11", min_distance); end
  endtask

  task automatic test_write_with_start();
    int cyc, bcyc;
    @(negedge clk);
    class_wr_en = 1'b1; class_wr_addr = 5'd0; class_wr_data = chunkQuery;
    start_search = 1'b1; query_hv = chunkQuery;
    @(negedge clk);
    class_wr_en = 1'b0; start_search = 1'b0;
    waitDone(cyc, bcyc);
    assertCount++; if (predicted_class !== 5'd0) begin failCount++; $display("[TB] FAIL wrstart_class: actual %0d required 0", predicted_class); end
    assertCount++; if (min_distance !== 13'd0) begin failCount++; $display("[TB] FAIL wrstart_dist: actual %0d required 0", min_distance); end
  endtask

`ifdef HDC_RP_MASK_EN
  task automatic test_mask();
    int cyc, bcyc;
    logic [HV_DIM-1:0] r;
    logic [HV_DIM-1:0] q;
    @(negedge clk);
    mask_wr_en   = 1'b1;
    mask_wr_data = {{(HV_DIM/2){1'b1}}, {(HV_DIM/2){1'b0}}};
    @(negedge clk);
    mask_wr_en = 1'b0;
    r = randHv();
    q = r;
    for (int i = 0; i < 100; i++) q[i] = ~q[i];
    for (int c = 0; c < CLASS_COUNT; c++) begin
      classVec[c] = q;
      if (c == 2) classVec[c] = r;
      else classVec[c][3000 + c] = ~classVec[c][3000 + c];
    end
    loadClasses();
    launch(q);
    waitDone(cyc, bcyc);
    assertCount++; if (predicted_class !== 5'd2) begin failCount++; $display("[TB] FAIL mask_class: actual %0d required 2", predicted_class); end
    assertCount++; if (min_distance !== 13'd0) begin failCount++; $display("[TB] FAIL mask_dist: actual %0d required 0", min_distance); end
  endtask
`endif

  initial begin
    nrst          = 1'b1;
    en            = 1'b1;
    class_wr_en   = 1'b0;
    class_wr_addr = '0;
    class_wr_data = '0;
    start_search  = 1'b0;
    query_hv      = '0;
`ifdef HDC_RP_MASK_EN
    mask_wr_en    = 1'b0;
    mask_wr_data  = '0;
`endif
    test_reset();
    test_exact_match();
    test_ties();
    test_chunk_accounting();
    test_protocol();
    test_enable_freeze();
    test_reset_mid_search();
    test_write_with_start();
`ifdef HDC_RP_MASK_EN
    test_mask();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/hdc_assoc_search.md
Name: hdc_assoc_search

Overview:
- Inference-side consumer of the encoder's `encoded_hv`.
- Holds one class hypervector per class in an internal register file.
- On `start_search`, latches the query hypervector and accumulates Hamming distances to every class, one dimension chunk per cycle.
- Then runs a sequential argmin, one class per cycle, and reports the predicted class and its distance.

Parameters:
- HV_DIM, 4096, hypervector width in bits.
- CLASS_COUNT, 26, number of stored class hypervectors.
- CHUNK_W, 1024, dimensions compared per cycle; HV_DIM must be an integer multiple of CHUNK_W.
- Derived: CHUNKS = HV_DIM/CHUNK_W (default 4); DIST_W = $clog2(HV_DIM+1) (13); CLS_W = $clog2(CLASS_COUNT) (5).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- nrst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, every register holds its value.
- class_wr_en  in  1  write one class hypervector.
- class_wr_addr  in  CLS_W  class index to write.
- class_wr_data  in  HV_DIM  class hypervector to write.
- start_search  in  1  begin a search, sampled only in IDLE.
- query_hv  in  HV_DIM  encoded hypervector, captured on an accepted start.
- busy  out  1  high from the accepted start through the DONE cycle.
- search_done  out  1  one-cycle pulse in the DONE state.
- predicted_class  out  CLS_W  index of the minimum-distance class; held until the next DONE.
- min_distance  out  DIST_W  distance of the predicted class; held until the next DONE.

Behaviour:
- Reset (async) forces all of the following to 0 immediately, including mid-search; the state goes to IDLE:
  - state, chunk counter, class counter, all distance accumulators
  - busy, search_done, predicted_class, min_distance
- Reset does not clear the class register file contents, which remain undefined until written.
- FSM states and transitions:
  - IDLE: when `start_search`, latch `query_hv`, clear accumulators, chunk_ctr := 0, go to DIST.
  - DIST: for every class c in parallel, acc[c] += popcount(query chunk XOR class[c] chunk), using chunk index chunk_ctr, bits [chunk_ctr*CHUNK_W +: CHUNK_W]. chunk_ctr increments each cycle. After the cycle with chunk_ctr = CHUNKS-1, go to ARGMIN with cls_ctr := 0, best_idx := 0, best_dist := all-ones.
  - ARGMIN: if acc[cls_ctr] < best_dist (strict), update best_idx and best_dist. After cls_ctr = CLASS_COUNT-1, go to DONE.
  - DONE: copy best values to `predicted_class` and `min_distance`, pulse `search_done`, then return to IDLE.
- Latency: `search_done` is high exactly CHUNKS+CLASS_COUNT+1 cycles after the edge that accepts start (31 cycles at defaults).
- Tie rule: the strict-less compare means the lowest class index wins among equal distances.
- Accumulators are DIST_W bits wide and cannot overflow, since the maximum value is HV_DIM.
- `start_search` while busy is ignored; it is not queued.
- `class_wr_en` while busy is ignored, so class memory stays stable during a search. In IDLE, the write lands on the edge.
- If a write and a start occur in the same IDLE cycle, the write takes effect; the search uses the new contents because distance evaluation begins next cycle.
- `class_wr_addr` >= CLASS_COUNT: the write is dropped.
- `en` low: the FSM and counters freeze. `search_done` stays at its current value; it is not re-pulsed on resume.

Optional Feature:
- Macro: HDC_RP_MASK_EN (redundancy-pruning dimension mask).
- With the macro:
  - Extra ports `mask_wr_en` (in, 1) and `mask_wr_data` (in, HV_DIM).
  - The internal mask register resets to all-ones. It is written only in IDLE.
  - In DIST, each chunk's XOR result is ANDed with the matching mask chunk, so pruned dimensions (mask bit 0) never add distance.
- Without the macro: no mask ports and no mask register; every dimension counts.

Decomposition:
- Package `hdc_search_pkg` holds:
  - default constants HV_DIM, CLASS_COUNT, CHUNK_W
  - derived widths CHUNKS, DIST_W, CLS_W
  - the state typedef enum {IDLE, DIST, ARGMIN, DONE}
- Sub-module `hdc_chunk_popcount`: combinational XOR (plus optional mask AND) and popcount of CHUNK_W bits, output $clog2(CHUNK_W+1) bits. Instantiated CLASS_COUNT times.

Test Plan:
- Exact match: class 0 = all zeros, class 1 = all ones, others random; query all zeros → predicted_class=0, min_distance=0, search_done at start+31 cycles.
- Ties: classes 3 and 5 both equal to the query, all others at distance ≥100 → predicted_class=3, min_distance=0.
- Chunk accounting: query flips only bit 4095 and bits 0..9 relative to class 7, and every other class is farther → predicted_class=7, min_distance=11.
- Protocol: start pulsed again at start+5, and a class write at start+3 → no restart and memory unchanged. Done arrives at start+31 with the original result; busy stays high for 31 cycles.
- Reset mid-search: assert nrst at start+10 → busy=0, search_done=0, predicted_class=0 immediately. A new search after release completes normally.
- HDC_RP_MASK_EN: mask clears bits 0..2047, and the query differs from class 2 only in bits 0..99 → min_distance=0, predicted_class=2.
